// File: rtl/count_sequencer_if.sv
// Control/status bundle between system control logic and the count sequencer.
interface count_sequencer_if #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4,
  parameter int WRAP_W  = 8
);
  logic               start;
  logic               stop;
  logic               pause;
  logic [WIDTH-1:0]   limit;
  logic [PRESC_W-1:0] presc;
  logic               auto_reload;
  logic [WIDTH-1:0]   count;
  logic               busy;
  logic               done;
  logic [WRAP_W-1:0]  wraps;
  logic [1:0]         state;

  modport master (
    output start, stop, pause, limit, presc, auto_reload,
    input  count, busy, done, wraps, state
  );

  modport slave (
    input  start, stop, pause, limit, presc, auto_reload,
    output count, busy, done, wraps, state
  );
endinterface

// File: rtl/count_sequencer.sv
// Sequencer for a paced WIDTH-bit up-counter: start/stop/pause control,
// programmable terminal value and prescaler, one-shot or auto-reload.
module count_sequencer #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4,
  parameter int WRAP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  count_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   count_q;
  logic [PRESC_W-1:0] presc_cnt;
  logic [WIDTH-1:0]   limit_l;
  logic [PRESC_W-1:0] presc_l;
  logic               auto_l;
  logic [WRAP_W-1:0]  wraps_q;
  logic               busy_q;
  logic               done_q;

  // NOTE: all state lives in one clocked block with non-blocking assignments,
  // so every register sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      presc_cnt <= '0;
      limit_l   <= '0;
      presc_l   <= '0;
      auto_l    <= 1'b0;
      wraps_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.stop) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
          end else if (bus.start) begin
            limit_l   <= bus.limit;
            presc_l   <= bus.presc;
            auto_l    <= bus.auto_reload;
            count_q   <= '0;
            presc_cnt <= '0;
            wraps_q   <= '0;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end
        end

        RUN, PAUSE: begin
          if (bus.stop) begin
            state_q   <= IDLE;
            count_q   <= '0;
            presc_cnt <= '0;
            busy_q    <= 1'b0;
          end else if (bus.pause) begin
            state_q <= PAUSE;
          end else begin
            // Leaving PAUSE advances on the same edge, so a pause of N cycles
            // delays the sequence by exactly N cycles.
            state_q <= RUN;
            if (presc_cnt == presc_l) begin
              presc_cnt <= '0;
              if (count_q == limit_l) begin
                done_q <= 1'b1;
                if (auto_l) begin
                  count_q <= '0;
                  if (wraps_q != '1) wraps_q <= wraps_q + WRAP_W'(1);
                end else begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                end
              end else begin
                count_q <= count_q + WIDTH'(1);
              end
            end else begin
              presc_cnt <= presc_cnt + PRESC_W'(1);
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.wraps = wraps_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed self-checking bench for count_sequencer, one task per scenario.
module tb_count_sequencer;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  count_sequencer_if #(.WIDTH(4), .PRESC_W(4), .WRAP_W(8)) bus ();

  count_sequencer #(.WIDTH(4), .PRESC_W(4), .WRAP_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then read 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  task automatic start_run(input logic [3:0] lim, input logic [3:0] pr, input logic ar);
    bus.limit = lim;
    bus.presc = pr;
    bus.auto_reload = ar;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.state !== S_RUN || bus.count !== 4'd0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL start_accept: state=%b count=%0d busy=%b, want state=01 count=0 busy=1",
               bus.state, bus.count, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if (bus.state !== S_IDLE || bus.count !== 4'd0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.wraps !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: state=%b count=%0d busy=%b done=%b wraps=%0d, want all 0",
               bus.state, bus.count, bus.busy, bus.done, bus.wraps);
    end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_run();
    start_run(4'd9, 4'd0, 1'b0);
    step(); step(); step();
    checks++;
    if (bus.count !== 4'd3) begin
      failures++;
      $display("FAIL midrun_pre: count=%0d want 3", bus.count);
    end
    rst = 1'b0;
    #2;
    checks++;
    if (bus.count !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.state !== S_IDLE) begin
      failures++;
      $display("FAIL midrun_async_reset: count=%0d busy=%b done=%b state=%b, want 0 0 0 00",
               bus.count, bus.busy, bus.done, bus.state);
    end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_one_shot();
    start_run(4'd9, 4'd0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (bus.count !== ((k < 10) ? 4'(k) : 4'd9) || bus.done !== (k == 10)) begin
        failures++;
        $display("FAIL one_shot k=%0d: count=%0d done=%b, want count=%0d done=%b",
                 k, bus.count, bus.done, (k < 10) ? k : 9, (k == 10));
      end
    end
    step();
    checks++;
    if (bus.state !== S_DONE || bus.count !== 4'd9 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL one_shot_end: state=%b count=%0d busy=%b done=%b, want 11 9 0 0",
               bus.state, bus.count, bus.busy, bus.done);
    end
  endtask

  task automatic test_prescaled_auto();
    go_idle();
    start_run(4'd3, 4'd2, 1'b1);
    for (int k = 1; k <= 36; k++) begin
      step();
      checks++;
      if (bus.count !== 4'((k / 3) % 4) || bus.done !== (k % 12 == 0) ||
          bus.wraps !== 8'(k / 12) || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL presc_auto k=%0d: count=%0d done=%b wraps=%0d busy=%b, want %0d %b %0d 1",
                 k, bus.count, bus.done, bus.wraps, bus.busy, (k / 3) % 4, (k % 12 == 0), k / 12);
      end
    end
  endtask

  task automatic test_pause();
    go_idle();
    start_run(4'd5, 4'd1, 1'b0);
    step(); step(); step(); step();
    checks++;
    if (bus.count !== 4'd2) begin
      failures++;
      $display("FAIL pause_pre: count=%0d want 2", bus.count);
    end
    bus.pause = 1'b1;
    for (int k = 5; k <= 8; k++) begin
      step();
      checks++;
      if (bus.state !== S_PAUSE || bus.count !== 4'd2 || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL pause_hold k=%0d: state=%b count=%0d busy=%b, want 10 2 1",
                 k, bus.state, bus.count, bus.busy);
      end
    end
    bus.pause = 1'b0;
    for (int k = 9; k <= 16; k++) begin
      step();
      checks++;
      if (bus.done !== (k == 16)) begin
        failures++;
        $display("FAIL pause_done k=%0d: done=%b want %b", k, bus.done, (k == 16));
      end
    end
    checks++;
    if (bus.state !== S_DONE || bus.count !== 4'd5) begin
      failures++;
      $display("FAIL pause_end: state=%b count=%0d, want 11 5", bus.state, bus.count);
    end
  endtask

  task automatic test_stop_priority();
    go_idle();
    start_run(4'd9, 4'd0, 1'b0);
    step(); step(); step(); step();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    checks++;
    if (bus.state !== S_IDLE || bus.count !== 4'd0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_run: state=%b count=%0d done=%b busy=%b, want 00 0 0 0",
               bus.state, bus.count, bus.done, bus.busy);
    end
    start_run(4'd1, 4'd0, 1'b0);
    step(); step();
    checks++;
    if (bus.state !== S_DONE) begin
      failures++;
      $display("FAIL stop_reach_done: state=%b want 11", bus.state);
    end
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    checks++;
    if (bus.state !== S_IDLE || bus.count !== 4'd0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL start_stop_done: state=%b count=%0d busy=%b, want 00 0 0",
               bus.state, bus.count, bus.busy);
    end
  endtask

  task automatic test_limit0_saturate();
    go_idle();
    start_run(4'd0, 4'd0, 1'b1);
    for (int k = 1; k <= 300; k++) begin
      step();
      checks++;
      if (bus.done !== 1'b1 || bus.count !== 4'd0 || bus.wraps !== 8'((k < 255) ? k : 255)) begin
        failures++;
        $display("FAIL limit0_sat k=%0d: done=%b count=%0d wraps=%0d, want 1 0 %0d",
                 k, bus.done, bus.count, bus.wraps, (k < 255) ? k : 255);
      end
    end
  endtask

  task automatic test_start_while_busy();
    go_idle();
    start_run(4'd2, 4'd0, 1'b0);
    bus.limit = 4'd7;
    bus.auto_reload = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.count !== 4'd1 || bus.state !== S_RUN) begin
      failures++;
      $display("FAIL busy_start_ignored: count=%0d state=%b, want 1 01", bus.count, bus.state);
    end
    step(); step();
    checks++;
    if (bus.done !== 1'b1 || bus.count !== 4'd2 || bus.state !== S_DONE) begin
      failures++;
      $display("FAIL busy_no_relatch: done=%b count=%0d state=%b, want 1 2 11",
               bus.done, bus.count, bus.state);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.pause = 1'b0;
    bus.limit = '0;
    bus.presc = '0;
    bus.auto_reload = 1'b0;
    test_reset();
    test_reset_mid_run();
    test_one_shot();
    test_prescaled_auto();
    test_pause();
    test_stop_priority();
    test_limit0_saturate();
    test_start_while_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
